vga_sprite_array_core: RTL and testbench
========================================

VGA_SPRITE_ARRAY_CORE -- requirements
Module: vga_sprite_array_core

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- CD, 12, colour depth.
- NUM_SPRITES, 20, sprite count, legal range 1..32.
- ADDR_WIDTH, 10, pattern RAM address width; 1024 x 2-bit pixels, four 16x16 images.
- KEY_COLOR, 0, chroma key colour.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-low.
- x, in, 11, frame counter column.
- y, in, 11, frame counter row.
- cs, in, 1, slot select.
- write, in, 1, write strobe.
- addr, in, 14, slot address.
- wr_data, in, 32, write data.
- rd_data, out, 32, read data.
- si_rgb, in, CD, upstream stream pixel.
- so_rgb, out, CD, downstream stream pixel.

Function
REQ-003 Write decode: wr_en = cs & write; addr[13]=0 writes wr_data[1:0] to pattern RAM at addr[ADDR_WIDTH-1:0]; addr[13]=1 writes registers selected by addr[7:0].
REQ-004 Global register map SHALL be: 0 = bypass (wr_data[0]); 1 = commit_mode (wr_data[0]); 2 = collision clear (any write).
REQ-005 Per-sprite register map: sprite i SHALL use words 4+4i (x, 11 bits), 5+4i (y, 11 bits) and 6+4i (ctrl, 6 bits); unmapped words are ignored.
REQ-006 ctrl bit fields SHALL be: [0] enable, [1] horizontal flip, [3:2] image select, [5:4] palette select.
REQ-007 Each sprite SHALL have pending and active copies of x, y and ctrl; bus writes update pending only.
REQ-008 Commit behaviour SHALL be: commit_mode=0, active follows pending one cycle after the write; commit_mode=1, all active copies load pending only in the cycle with x==0 && y==0.
REQ-009 A write in the commit cycle SHALL land in pending and become active at the next frame start.
REQ-010 Hit rule: sprite i is hit when enabled && x>=xi && x<xi+16 && y>=yi && y<yi+16, with the sums computed in 12 bits (no wrap).
REQ-011 Pipeline stage 0: the lowest-index hit sprite SHALL win; its RAM address = {image, row, col}, where col is inverted when hflip=1.
REQ-012 Pipeline stage 1: synchronous pattern RAM read; winner index, palette select and hit flag are registered alongside.
REQ-013 Pipeline stage 2: pixel code 0, or no hit, SHALL yield KEY_COLOR; codes 1..3 index the fixed palette table (4 palettes x 3 colours).
REQ-014 so_rgb SHALL be registered, with a latency of exactly 2 clk from x/y.
REQ-015 si_rgb SHALL be delayed 2 clk internally for alignment.
REQ-016 so_rgb SHALL be delayed si_rgb when bypass=1 or the sprite colour equals KEY_COLOR; otherwise it SHALL be the sprite colour.
REQ-017 Transparent pixels of a higher-priority sprite SHALL NOT reveal lower sprites (single-winner compositing).
REQ-018 rd_data SHALL be combinational: addr[13]=1 && addr[7:0]==2 returns the collision vector zero-extended to 32 bits; all other addresses return 0.

Reset
REQ-019 While reset=0 at a clk edge, all of the following SHALL clear to 0: pending and active registers, bypass, commit_mode, collision vector, pipeline registers and so_rgb.
REQ-020 Pattern RAM contents SHALL NOT be reset.
REQ-021 Reset asserted mid-frame SHALL take effect at the next edge; the output SHALL be 0 for the 2 cycles following release.

Configuration
REQ-022 With SPRITE_COLLISION_EN defined, the following SHALL apply:
- Bit i of the sticky collision vector is set in any cycle where sprite i is hit while at least one other sprite is hit.
- A write to word 2 clears the vector.
- A simultaneous set and clear leaves set bits set.
REQ-023 Without SPRITE_COLLISION_EN, no collision logic SHALL exist and word 2 SHALL read 0.

Structure
REQ-024 Package vga_sprite_pkg SHALL hold:
- the sprite_regs_t struct (x, y, ctrl);
- the register offset constants;
- SPRITE_SIZE=16;
- the palette table constant.
REQ-025 The pattern RAM SHALL be the sub-module sprite_pattern_ram: simple dual-port, one write port, one synchronous read port.

Verification
REQ-026 Scenario single sprite: sprite 0 at (100,50), enabled, image 0 pixel(0,0)=1, palette 0 -> so_rgb = palette[0][0] two clk after x=100,y=50; si_rgb at x=99.
REQ-027 Scenario priority: sprites 3 and 7 both at (200,200) -> sprite 3 colour shown; disabling sprite 3 -> sprite 7 shown.
REQ-028 Scenario sync commit: commit_mode=1, write x0=300 mid-frame -> old position drawn until x==0,y==0, new position after.
REQ-029 Scenario flip and bypass:
- hflip=1 -> column 15 pattern appears at x=xi.
- bypass=1 -> so_rgb equals si_rgb delayed 2 clk everywhere.
REQ-030 Scenario collision (macro on): sprites 1 and 2 overlapping -> rd_data=0x6; clear written in the same cycle as an overlap -> still 0x6; clear with no overlap -> 0.

Source files
------------

// File: rtl/vga_sprite_pkg.sv
// Shared types and constants for the sprite array core: register map,
// per-sprite register layout, sprite geometry and the fixed colour palettes.
package vga_sprite_pkg;

  localparam int SPRITE_SIZE = 16;
  localparam int PIX_W       = 2;
  localparam int PAL_W       = 12;

  localparam int REG_BYPASS      = 0;
  localparam int REG_COMMIT      = 1;
  localparam int REG_COLL_CLR    = 2;
  localparam int REG_SPRITE_BASE = 4;
  localparam int REG_STRIDE      = 4;
  localparam int OFF_X           = 0;
  localparam int OFF_Y           = 1;
  localparam int OFF_CTRL        = 2;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_HFLIP = 1;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [5:0]  ctrl;
  } sprite_regs_t;

  // Indexed [palette][pixel code - 1]; code 0 is always transparent.
  localparam logic [PAL_W-1:0] PALETTE [4][3] = '{
    '{12'hF00, 12'h0F0, 12'h00F},
    '{12'hFF0, 12'h0FF, 12'hF0F},
    '{12'h888, 12'hFFF, 12'h444},
    '{12'hF80, 12'h08F, 12'h8F0}
  };

endpackage

// File: rtl/sprite_pattern_ram.sv
// Sprite pattern store: simple dual-port RAM, one write port and one
// registered read port. Contents are never reset.
module sprite_pattern_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_W     = 2
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/vga_sprite_array_core.sv
// Sprite overlay on a VGA pixel stream: lowest-index hit sprite wins, 2-clk latency.
// Optional sticky collision vector enabled by defining SPRITE_COLLISION_EN.
module vga_sprite_array_core
  import vga_sprite_pkg::*;
#(
  parameter int              CD          = 12,
  parameter int              NUM_SPRITES = 20,
  parameter int              ADDR_WIDTH  = 10,
  parameter logic [CD-1:0]   KEY_COLOR   = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  function automatic logic [CD-1:0] sprite_colour(input logic       hit,
                                                  input logic [1:0] pal,
                                                  input logic [1:0] code);
    if (!hit || code == 2'd0) return KEY_COLOR;
    return CD'(PALETTE[pal][code - 2'd1]);
  endfunction

  logic         w_wr_en, w_wr_ram, w_wr_reg, w_frame_start;
  logic [7:0]   w_reg_off;

  sprite_regs_t r_pend [NUM_SPRITES];
  sprite_regs_t r_act  [NUM_SPRITES];
  logic         r_bypass, r_commit;

  assign w_wr_en       = cs & write;
  assign w_wr_ram      = w_wr_en & ~addr[13];
  assign w_wr_reg      = w_wr_en & addr[13];
  assign w_reg_off     = addr[7:0];
  assign w_frame_start = (x == 11'd0) && (y == 11'd0);

  // Bus writes land in the pending copy; active copies reload from pending
  // every cycle, or only at frame start in synchronous-commit mode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bypass <= 1'b0;
      r_commit <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_pend[i] <= '0;
        r_act[i]  <= '0;
      end
    end else begin
      if (w_wr_reg && w_reg_off == 8'(REG_BYPASS)) r_bypass <= wr_data[0];
      if (w_wr_reg && w_reg_off == 8'(REG_COMMIT)) r_commit <= wr_data[0];
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (!r_commit || w_frame_start) r_act[i] <= r_pend[i];
        if (w_wr_reg && w_reg_off == 8'(REG_SPRITE_BASE + REG_STRIDE*i + OFF_X))
          r_pend[i].x <= wr_data[10:0];
        if (w_wr_reg && w_reg_off == 8'(REG_SPRITE_BASE + REG_STRIDE*i + OFF_Y))
          r_pend[i].y <= wr_data[10:0];
        if (w_wr_reg && w_reg_off == 8'(REG_SPRITE_BASE + REG_STRIDE*i + OFF_CTRL))
          r_pend[i].ctrl <= wr_data[5:0];
      end
    end
  end

  // ---- stage 0: hit test, priority select, pattern address ----
  logic [NUM_SPRITES-1:0] w_hit_p0;
  logic                   w_any_p0;
  logic [IDX_W-1:0]       w_win_p0;
  logic [3:0]             w_row_p0, w_col_p0;
  logic [1:0]             w_img_p0, w_pal_p0;
  logic [ADDR_WIDTH-1:0]  w_addr_p0;

  always_comb begin
    w_hit_p0 = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_hit_p0[i] = r_act[i].ctrl[CTRL_EN]
        && ({1'b0, x} >= {1'b0, r_act[i].x})
        && ({1'b0, x} <  ({1'b0, r_act[i].x} + 12'(SPRITE_SIZE)))
        && ({1'b0, y} >= {1'b0, r_act[i].y})
        && ({1'b0, y} <  ({1'b0, r_act[i].y} + 12'(SPRITE_SIZE)));
    end
  end

  // Scan high to low so the lowest-index hit is the last assignment.
  always_comb begin
    w_any_p0 = 1'b0;
    w_win_p0 = '0;
    w_row_p0 = '0;
    w_col_p0 = '0;
    w_img_p0 = '0;
    w_pal_p0 = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit_p0[i]) begin
        w_any_p0 = 1'b1;
        w_win_p0 = IDX_W'(i);
        w_row_p0 = y[3:0] - r_act[i].y[3:0];
        w_col_p0 = (x[3:0] - r_act[i].x[3:0]) ^ {4{r_act[i].ctrl[CTRL_HFLIP]}};
        w_img_p0 = r_act[i].ctrl[3:2];
        w_pal_p0 = r_act[i].ctrl[5:4];
      end
    end
  end

  assign w_addr_p0 = ADDR_WIDTH'({w_img_p0, w_row_p0, w_col_p0});

  // ---- stage 1: pattern read with winner info and stream pixel alongside ----
  logic [PIX_W-1:0] w_pix_p1;
  logic             r_hit_p1;
  logic [IDX_W-1:0] r_win_p1;
  logic [1:0]       r_pal_p1;
  logic [CD-1:0]    r_si_p1;

  sprite_pattern_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_W     (PIX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ram),
    .i_waddr (addr[ADDR_WIDTH-1:0]),
    .i_wdata (wr_data[PIX_W-1:0]),
    .i_raddr (w_addr_p0),
    .o_rdata (w_pix_p1)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hit_p1 <= 1'b0;
      r_win_p1 <= '0;
      r_pal_p1 <= '0;
      r_si_p1  <= '0;
    end else begin
      r_hit_p1 <= w_any_p0;
      r_win_p1 <= w_win_p0;
      r_pal_p1 <= w_pal_p0;
      r_si_p1  <= si_rgb;
    end
  end

  // ---- stage 2: palette lookup and compositing ----
  logic [CD-1:0] w_colour_p2;

  assign w_colour_p2 = sprite_colour(r_hit_p1, r_pal_p1, w_pix_p1);

  always_ff @(posedge clk) begin
    if (!reset) so_rgb <= '0;
    else        so_rgb <= (r_bypass || w_colour_p2 == KEY_COLOR) ? r_si_p1 : w_colour_p2;
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] r_coll, w_coll_set;

  // x & (x-1) is non-zero exactly when two or more sprites are hit.
  assign w_coll_set = ((w_hit_p0 & (w_hit_p0 - 1'b1)) != '0) ? w_hit_p0 : '0;

  always_ff @(posedge clk) begin
    if (!reset)
      r_coll <= '0;
    else if (w_wr_reg && w_reg_off == 8'(REG_COLL_CLR))
      r_coll <= w_coll_set;
    else
      r_coll <= r_coll | w_coll_set;
  end

  assign rd_data = (addr[13] && addr[7:0] == 8'(REG_COLL_CLR)) ? 32'(r_coll) : 32'd0;
`else
  assign rd_data = 32'd0;
`endif

  logic w_unused;
  assign w_unused = ^{wr_data[31:11], addr[12:8], r_win_p1};

endmodule

// File: tb/tb_vga_sprite_array_core.sv
// Randomised scoreboard bench for vga_sprite_array_core against a frame-level reference model.
`timescale 1ns/1ps
module tb_vga_sprite_array_core;

  localparam int CD = 12;
  localparam int N  = 20;
  localparam logic [CD-1:0] KEY = '0;
  localparam logic [11:0] PAL [4][3] = '{
    '{12'hF00, 12'h0F0, 12'h00F},
    '{12'hFF0, 12'h0FF, 12'hF0F},
    '{12'h888, 12'hFFF, 12'h444},
    '{12'hF80, 12'h08F, 12'h8F0}
  };

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   x, y;
  logic          cs, write;
  logic [13:0]   addr;
  logic [31:0]   wr_data, rd_data;
  logic [CD-1:0] si_rgb, so_rgb;

  vga_sprite_array_core #(.CD(CD), .NUM_SPRITES(N), .ADDR_WIDTH(10), .KEY_COLOR(KEY)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [CD-1:0] exp_q[$];
  logic [CD-1:0] mon_e;
  logic rst_drive;

  // Reference state: pending/active sprite settings, pattern memory, globals.
  int m_px[N], m_py[N], m_pc[N], m_ax[N], m_ay[N], m_ac[N];
  int m_ram[1024];
  bit m_bypass, m_commit;
  logic [31:0] m_coll;
  logic [CD-1:0] p_c, p_si;

  task automatic model_step();
    int win, nh, cx, ry, code, off, k, s;
    logic [31:0] hv;
    logic [CD-1:0] c;
    if (reset !== 1'b1) begin
      exp_q.push_back('0);
      for (int i = 0; i < N; i++) begin
        m_px[i] = 0; m_py[i] = 0; m_pc[i] = 0; m_ax[i] = 0; m_ay[i] = 0; m_ac[i] = 0;
      end
      m_bypass = 0; m_commit = 0; m_coll = 0; p_c = KEY; p_si = '0;
      return;
    end
    exp_q.push_back((m_bypass || p_c == KEY) ? p_si : p_c);
    win = -1; nh = 0; hv = 0;
    for (int i = 0; i < N; i++) begin
      if ((m_ac[i] & 1) != 0 && int'(x) >= m_ax[i] && int'(x) < m_ax[i] + 16 &&
          int'(y) >= m_ay[i] && int'(y) < m_ay[i] + 16) begin
        nh++; hv[i] = 1'b1;
        if (win < 0) win = i;
      end
    end
    c = KEY;
    if (win >= 0) begin
      cx = int'(x) - m_ax[win];
      ry = int'(y) - m_ay[win];
      if ((m_ac[win] & 2) != 0) cx = 15 - cx;
      code = m_ram[((m_ac[win] >> 2) & 3) * 256 + ry * 16 + cx];
      if (code != 0) c = PAL[(m_ac[win] >> 4) & 3][code - 1];
    end
    p_c = c; p_si = si_rgb;
`ifdef SPRITE_COLLISION_EN
    if (cs && write && addr[13] && addr[7:0] == 8'd2) m_coll = 0;
    if (nh >= 2) m_coll = m_coll | hv;
`endif
    if (!m_commit || (x == 0 && y == 0))
      for (int i = 0; i < N; i++) begin m_ax[i] = m_px[i]; m_ay[i] = m_py[i]; m_ac[i] = m_pc[i]; end
    if (cs && write) begin
      if (!addr[13]) m_ram[addr[9:0]] = int'(wr_data[1:0]);
      else begin
        off = int'(addr[7:0]);
        if (off == 0) m_bypass = wr_data[0];
        else if (off == 1) m_commit = wr_data[0];
        else if (off >= 4) begin
          k = (off - 4) / 4; s = (off - 4) % 4;
          if (k < N && s == 0) m_px[k] = int'(wr_data[10:0]);
          if (k < N && s == 1) m_py[k] = int'(wr_data[10:0]);
          if (k < N && s == 2) m_pc[k] = int'(wr_data[5:0]);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: the output register presents a new pixel every cycle.
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (so_rgb !== mon_e) begin
        failures++;
        $display("FAIL so_rgb t=%0t x=%0d y=%0d got=%h exp=%h", $time, x, y, so_rgb, mon_e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] exp_rd(input logic [13:0] a);
    if (a[13] && a[7:0] == 8'd2) return m_coll;
    return 32'd0;
  endfunction

  task automatic cyc(input int xx, input int yy, input bit c = 1'b0, input bit w = 1'b0,
                     input logic [13:0] a = 14'd0, input logic [31:0] d = 32'd0);
    logic [31:0] e;
    @(negedge clk);
    reset = rst_drive;
    x = 11'(xx); y = 11'(yy); cs = c; write = w; addr = a; wr_data = d;
    si_rgb = CD'($urandom);
    #1;
    if (a[13] && !w) begin
      e = exp_rd(a);
      checks++;
      if (rd_data !== e) begin
        failures++;
        $display("FAIL rd_data addr=%h got=%h exp=%h", a, rd_data, e);
      end
    end
  endtask

  task automatic wreg(input int off, input int d, input int xx = 1000, input int yy = 1000);
    cyc(xx, yy, 1'b1, 1'b1, {1'b1, 5'd0, 8'(off)}, 32'(d));
  endtask

  task automatic rreg(input int off, input int xx = 1000, input int yy = 1000);
    cyc(xx, yy, 1'b1, 1'b0, {1'b1, 5'd0, 8'(off)}, 32'd0);
  endtask

  task automatic sweep(input int x0, input int x1, input int y0, input int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) cyc(xx, yy);
  endtask

  initial begin
    int r, r2, xx, yy, k, s, d;
    reset = 1'b0; x = '0; y = '0; cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0; si_rgb = '0;
    rst_drive = 1'b0;
    for (int i = 0; i < 1024; i++) m_ram[i] = 0;
    for (int i = 0; i < 4; i++) cyc(10, 10);
    rst_drive = 1'b1;
    for (int a = 0; a < 1024; a++)
      cyc($urandom_range(0, 700), $urandom_range(0, 500), 1'b1, 1'b1, 14'(a), 32'($urandom_range(0, 3)));
    cyc(5, 5, 1'b1, 1'b1, 14'd0, 32'd1);
    cyc(5, 5, 1'b1, 1'b1, 14'd15, 32'd2);

    // single sprite at (100,50)
    wreg(4, 100); wreg(5, 50); wreg(6, 1);
    cyc(99, 50);
    sweep(96, 118, 49, 52);
    // priority: sprites 3 and 7 stacked
    wreg(16, 200); wreg(17, 200); wreg(18, 1 | (1 << 4));
    wreg(32, 200); wreg(33, 200); wreg(34, 1 | (1 << 2) | (2 << 4));
    sweep(198, 218, 199, 202);
    wreg(18, 0);
    sweep(198, 218, 199, 202);
    // horizontal flip and bypass
    wreg(6, 3);
    sweep(98, 118, 50, 51);
    wreg(0, 1);
    sweep(96, 118, 49, 51);
    wreg(0, 0);
    // synchronous commit, including a write in the commit cycle
    wreg(1, 1);
    wreg(4, 300, 150, 50);
    sweep(98, 118, 50, 51); sweep(298, 318, 50, 51);
    cyc(0, 0);
    sweep(98, 118, 50, 51); sweep(298, 318, 50, 51);
    wreg(4, 400, 0, 0);
    sweep(298, 318, 50, 50); sweep(398, 418, 50, 50);
    cyc(0, 0);
    sweep(298, 318, 50, 50); sweep(398, 418, 50, 50);
    wreg(1, 0);
    // no-wrap boundary at the far corner and at the origin
    wreg(24, 2040); wreg(25, 2040); wreg(26, 1 | (3 << 4));
    wreg(28, 0); wreg(29, 0); wreg(30, 1 | (2 << 2));
    sweep(2034, 2047, 2039, 2041); sweep(0, 18, 0, 1); sweep(0, 5, 2040, 2040);
    // collision between sprites 1 and 2
    wreg(8, 500); wreg(9, 300); wreg(10, 1);
    wreg(12, 508); wreg(13, 304); wreg(14, 1 | (1 << 4));
    wreg(2, 0);
    rreg(2);
    sweep(506, 516, 303, 305);
    rreg(2); rreg(0); rreg(1);
    wreg(2, 0, 510, 305);
    rreg(2);
    wreg(2, 0);
    rreg(2);

    // randomised traffic
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin xx = 0; yy = 0; end
      else if (r < 55) begin
        k = $urandom_range(0, N - 1);
        xx = m_ax[k] + $urandom_range(0, 23) - 4; yy = m_ay[k] + $urandom_range(0, 23) - 4;
        if (xx < 0) xx = 0; if (xx > 2047) xx = 2047;
        if (yy < 0) yy = 0; if (yy > 2047) yy = 2047;
      end else begin xx = $urandom_range(0, 700); yy = $urandom_range(0, 500); end
      r2 = $urandom_range(0, 99);
      if (r2 < 10) begin
        k = $urandom_range(0, N - 1); s = $urandom_range(0, 3);
        if (s == 2) d = $urandom_range(0, 63) | ($urandom_range(0, 3) != 0 ? 1 : 0);
        else if ($urandom_range(0, 9) == 0) d = $urandom_range(1990, 2047);
        else d = 100 + $urandom_range(0, 60);
        wreg(4 + 4 * k + s, d, xx, yy);
      end
      else if (r2 < 11) wreg(0, ($urandom_range(0, 3) == 0) ? 1 : 0, xx, yy);
      else if (r2 < 12) wreg(1, $urandom_range(0, 1), xx, yy);
      else if (r2 < 13) wreg(2, 0, xx, yy);
      else if (r2 < 14) wreg($urandom_range(0, 1) ? 3 : 200, 32'hFFFF, xx, yy);
      else if (r2 < 15)
        cyc(xx, yy, 1'b1, 1'b1, {1'b0, 3'($urandom), 10'($urandom)}, 32'($urandom));
      else if (r2 < 20) rreg(($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : 2, xx, yy);
      else if (r2 < 21) begin rst_drive = 1'b0; cyc(xx, yy); rst_drive = 1'b1; end
      else cyc(xx, yy);
    end

    repeat (3) cyc(1000, 1000);
    @(posedge clk); @(negedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
